// File: rtl/game_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_timer_pkg
// Description : Shared state encoding, BCD constants and load-value helpers
//               for the game countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
package game_timer_pkg;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_run     = 2'd1;
    localparam logic [1:0] c_st_pause   = 2'd2;
    localparam logic [1:0] c_st_expired = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = c_st_idle,
        ST_RUN     = c_st_run,
        ST_PAUSE   = c_st_pause,
        ST_EXPIRED = c_st_expired
    } state_t;

    localparam logic [3:0] c_bcd_max  = 4'd9;
    localparam logic [3:0] c_bcd_zero = 4'd0;

    // A start value must be two legal BCD digits and not 00.
    function automatic logic load_valid(input logic [3:0] t, input logic [3:0] o);
        return (t <= c_bcd_max) && (o <= c_bcd_max) &&
               !((t == c_bcd_zero) && (o == c_bcd_zero));
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_timer_bcd_down2.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down2
// Description : Two-digit BCD decrementer, saturating at 00, with a flag
//               indicating that the decremented result is 00.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down2
    import game_timer_pkg::*;
(
    input  logic [3:0] i_tens,
    input  logic [3:0] i_ones,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones,
    output logic       o_zero
);

    logic w_in_zero;

    assign w_in_zero = (i_tens == c_bcd_zero) && (i_ones == c_bcd_zero);

    always_comb begin
        o_tens = i_tens;
        o_ones = i_ones;
        if (w_in_zero) begin
            o_tens = c_bcd_zero;
            o_ones = c_bcd_zero;
        end else if (i_ones == c_bcd_zero) begin
            o_tens = i_tens - 4'd1;
            o_ones = c_bcd_max;
        end else begin
            o_ones = i_ones - 4'd1;
        end
    end

    assign o_zero = (o_tens == c_bcd_zero) && (o_ones == c_bcd_zero);

endmodule
`default_nettype wire

// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
// Module      : game_timer
// Description : Two-digit BCD countdown timer stepped by rising edges of a
//               slow tick, with start/pause control and a timeout pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module game_timer
    import game_timer_pkg::*;
#(
    parameter logic [3:0] INIT_TENS = 4'd3,
    parameter logic [3:0] INIT_ONES = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       expired,
    output logic       timeout
);

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       timeout_q, timeout_d;
    logic       tick_dly_q, tick_dly_d;

    logic       w_edge;
    logic       w_load_ok;
    logic [3:0] w_load_tens;
    logic [3:0] w_load_ones;
    logic [3:0] w_dec_tens;
    logic [3:0] w_dec_ones;
    logic       w_dec_zero;

    // tick_dly resets high so a tick already high at reset release is not an edge.
    assign w_edge = tick_in & ~tick_dly_q;

    assign w_load_ok   = load_valid(load_tens, load_ones);
    assign w_load_tens = w_load_ok ? load_tens : INIT_TENS;
    assign w_load_ones = w_load_ok ? load_ones : INIT_ONES;

    bcd_down2 u_bcd_down2 (
        .i_tens (tens_q),
        .i_ones (ones_q),
        .o_tens (w_dec_tens),
        .o_ones (w_dec_ones),
        .o_zero (w_dec_zero)
    );

    always_comb begin
        state_d    = state_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        timeout_d  = 1'b0;
        tick_dly_d = tick_in;

        if (start) begin
            state_d = ST_RUN;
            tens_d  = w_load_tens;
            ones_d  = w_load_ones;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (w_edge) begin
                        tens_d = w_dec_tens;
                        ones_d = w_dec_ones;
                        if (w_dec_zero) begin
                            state_d   = ST_EXPIRED;
                            timeout_d = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    tens_d = c_bcd_zero;
                    ones_d = c_bcd_zero;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tens_q     <= INIT_TENS;
            ones_q     <= INIT_ONES;
            timeout_q  <= 1'b0;
            tick_dly_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            timeout_q  <= timeout_d;
            tick_dly_q <= tick_dly_d;
        end
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign running = (state_q == ST_RUN);
    assign expired = (state_q == ST_EXPIRED);
    assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_game_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_timer
// Description : Self-checking bench for game_timer against a count-based
//               reference model, directed scenarios then random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_in;
    logic       start;
    logic       pause;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       expired;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0=idle 1=run 2=pause 3=expired; count held as an integer 0..99.
    int m_phase;
    int m_count;
    int m_timeout;
    int m_tick_prev;

    game_timer #(.INIT_TENS(4'd3), .INIT_ONES(4'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_in   (tick_in),
        .start     (start),
        .pause     (pause),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .tens      (tens),
        .ones      (ones),
        .running   (running),
        .expired   (expired),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int lt, lo;
        bit rise;
        lt = int'(load_tens);
        lo = int'(load_ones);
        if (rst) begin
            m_phase     = 0;
            m_count     = 30;
            m_timeout   = 0;
            m_tick_prev = 1;
        end else begin
            rise        = (tick_in == 1'b1) && (m_tick_prev == 0);
            m_tick_prev = int'(tick_in);
            m_timeout   = 0;
            if (start) begin
                m_phase = 1;
                if (lt > 9 || lo > 9 || (lt == 0 && lo == 0)) m_count = 30;
                else m_count = lt * 10 + lo;
            end else if (m_phase == 1) begin
                if (pause) m_phase = 2;
                else if (rise) begin
                    m_count = m_count - 1;
                    if (m_count == 0) begin
                        m_phase   = 3;
                        m_timeout = 1;
                    end
                end
            end else if (m_phase == 2 && !pause) begin
                m_phase = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("tens",    32'(tens),    32'(m_count / 10));
        chk("ones",    32'(ones),    32'(m_count % 10));
        chk("running", 32'(running), 32'(m_phase == 1));
        chk("expired", 32'(expired), 32'(m_phase == 3));
        chk("timeout", 32'(timeout), 32'(m_timeout));
    endtask

    task automatic pulse_tick();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
    endtask

    task automatic do_start(input logic [3:0] t, input logic [3:0] o);
        load_tens = t;
        load_ones = o;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic chk_digits(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, tens, ones}, {24'd0, exp});
    endtask

    initial begin
        rst = 1'b1; tick_in = 1'b1; start = 1'b0; pause = 1'b0;
        load_tens = 4'd0; load_ones = 4'd0;
        m_phase = 0; m_count = 30; m_timeout = 0; m_tick_prev = 1;

        // Reset release with tick high: no false edge, idle at 3:0.
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        chk_digits("rst_digits", 8'h30);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        tick_in = 1'b0;
        cyc();

        do_start(4'd1, 4'd2);
        chk_digits("load12", 8'h12);
        tick_in = 1'b1; cyc(); chk_digits("dec_11", 8'h11); tick_in = 1'b0; cyc();
        tick_in = 1'b1; cyc(); chk_digits("dec_10", 8'h10); tick_in = 1'b0; cyc();
        tick_in = 1'b1; cyc(); chk_digits("dec_09", 8'h09); tick_in = 1'b0; cyc();

        do_start(4'd0, 4'd2);
        pulse_tick();
        chk_digits("dec_01", 8'h01);
        tick_in = 1'b1; cyc();
        chk_digits("exp_00", 8'h00);
        chk("exp_flag", 32'(expired), 32'd1);
        chk("exp_pulse", 32'(timeout), 32'd1);
        tick_in = 1'b0; cyc();
        chk("exp_pulse_end", 32'(timeout), 32'd0);
        pulse_tick();
        chk_digits("exp_hold", 8'h00);

        do_start(4'd2, 4'd5);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) pulse_tick();
        chk_digits("pause_hold", 8'h25);
        pause = 1'b0;
        cyc();
        pulse_tick();
        chk_digits("resume_24", 8'h24);

        do_start(4'hA, 4'd3);
        chk_digits("bad_load", 8'h30);
        do_start(4'd0, 4'd0);
        chk_digits("zero_load", 8'h30);
        load_tens = 4'd4; load_ones = 4'd5;
        start = 1'b1; pause = 1'b1; tick_in = 1'b1;
        cyc();
        start = 1'b0; pause = 1'b0; tick_in = 1'b0;
        chk_digits("start_prio", 8'h45);
        chk("start_prio_run", 32'(running), 32'd1);
        cyc();

        do_start(4'd1, 4'd7);
        rst = 1'b1; tick_in = 1'b1; start = 1'b1; pause = 1'b1;
        cyc();
        rst = 1'b0; start = 1'b0; pause = 1'b0; tick_in = 1'b0;
        chk_digits("rst_mid_run", 8'h30);
        chk("rst_mid_running", 32'(running), 32'd0);
        cyc();

        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            start   = ($urandom_range(0, 24) == 0);
            pause   = ($urandom_range(0, 5) == 0);
            tick_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                load_tens = 4'($urandom_range(0, 15));
                load_ones = 4'($urandom_range(0, 15));
            end else begin
                load_tens = 4'($urandom_range(0, 1));
                load_ones = 4'($urandom_range(0, 9));
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
